// File: rtl/hit_miss_tone_gen.sv
// Hit/miss tone generator: each new hit or miss code plays a fixed-length
// square-wave tone into the codec sample registers, silence otherwise.
module hit_miss_tone_gen #(
  parameter int HIT_HALF_PERIOD  = 28409,
  parameter int MISS_HALF_PERIOD = 113636,
  parameter int TONE_CYCLES      = 10000000,
  parameter int AMPLITUDE        = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  hit_miss,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        busy
);

  localparam int MAX_HALF =
    (HIT_HALF_PERIOD > MISS_HALF_PERIOD) ?
    HIT_HALF_PERIOD : MISS_HALF_PERIOD;
  localparam int DUR_W =
    (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
  localparam int HALF_W =
    (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

  localparam logic [DUR_W-1:0] DUR_LOAD =
    DUR_W'(TONE_CYCLES - 1);
  localparam logic [HALF_W-1:0] HIT_LOAD =
    HALF_W'(HIT_HALF_PERIOD - 1);
  localparam logic [HALF_W-1:0] MISS_LOAD =
    HALF_W'(MISS_HALF_PERIOD - 1);
  localparam logic signed [31:0] POS = 32'(AMPLITUDE);
  localparam logic signed [31:0] NEG = -POS;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state;
  logic [1:0]         hit_miss_q;
  logic               tone_sel;
  logic               phase;
  logic [DUR_W-1:0]   dur_cnt;
  logic [HALF_W-1:0]  half_cnt;
  logic signed [31:0] sample;

  logic              is_code;
  logic              event_fire;
  logic              new_sel;
  logic [HALF_W-1:0] new_load;
  logic [HALF_W-1:0] cur_load;

  assign is_code    = (hit_miss == 2'b01) ||
                      (hit_miss == 2'b10);
  assign event_fire = is_code && (hit_miss != hit_miss_q);
  assign new_sel    = hit_miss[1];
  assign new_load   = new_sel ? MISS_LOAD : HIT_LOAD;
  assign cur_load   = tone_sel ? MISS_LOAD : HIT_LOAD;

  // A retrigger is checked first so it wins over expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hit_miss_q <= 2'b00;
      tone_sel   <= 1'b0;
      phase      <= 1'b0;
      dur_cnt    <= '0;
      half_cnt   <= '0;
      sample     <= '0;
      busy       <= 1'b0;
    end else begin
      hit_miss_q <= hit_miss;
      if (event_fire) begin
        state    <= PLAY;
        tone_sel <= new_sel;
        dur_cnt  <= DUR_LOAD;
        half_cnt <= new_load;
        phase    <= 1'b1;
        sample   <= POS;
        busy     <= 1'b1;
      end else if (state == PLAY) begin
        if (dur_cnt == '0) begin
          state  <= IDLE;
          phase  <= 1'b0;
          sample <= '0;
          busy   <= 1'b0;
        end else begin
          dur_cnt <= dur_cnt - 1'b1;
          if (half_cnt == '0) begin
            half_cnt <= cur_load;
            phase    <= ~phase;
            sample   <= phase ? NEG : POS;
          end else begin
            half_cnt <= half_cnt - 1'b1;
            sample   <= phase ? POS : NEG;
          end
        end
      end else begin
        sample <= '0;
        busy   <= 1'b0;
      end
    end
  end

  // Codec takes whatever sample is held; timing never waits on it.
  assign write_audio_out         = audio_out_allowed & ~reset;
  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_hit_miss_tone_gen.sv
// Scoreboard bench for hit_miss_tone_gen with small tone parameters.
module tb_hit_miss_tone_gen;

  localparam int HH = 4;
  localparam int MH = 10;
  localparam int TC = 40;
  localparam int AMP = 1000;

  logic        clk;
  logic        reset;
  logic [1:0]  hit_miss;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        busy;

  hit_miss_tone_gen #(
    .HIT_HALF_PERIOD (HH),
    .MISS_HALF_PERIOD(MH),
    .TONE_CYCLES     (TC),
    .AMPLITUDE       (AMP)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .hit_miss               (hit_miss),
    .audio_out_allowed      (audio_out_allowed),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .busy                   (busy)
  );

  typedef struct packed {
    logic        wr;
    logic        bs;
    logic [31:0] smp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   tag = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_busy(int i);
    return (i >= 0) && (i < TC);
  endfunction

  function automatic logic [31:0] exp_smp(int i, int h);
    logic signed [31:0] p;
    p = AMP;
    if ((i < 0) || (i >= TC)) return 32'd0;
    return (((i / h) % 2) == 0) ? p : -p;
  endfunction

  // i = tone offset of the registered outputs visible this cycle, -1 = idle
  task automatic cyc(input logic [1:0] hm, input logic al,
                     input logic rs, input int i, input int h);
    exp_t e;
    hit_miss          = hm;
    audio_out_allowed = al;
    reset             = rs;
    e.wr  = al & ~rs;
    e.bs  = exp_busy(i);
    e.smp = exp_smp(i, h);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tag++;
      checks += 4;
      if (write_audio_out !== e.wr) begin
        failures++;
        $display("FAIL write #%0d got=%b exp=%b", tag,
                 write_audio_out, e.wr);
      end
      if (busy !== e.bs) begin
        failures++;
        $display("FAIL busy #%0d got=%b exp=%b", tag, busy, e.bs);
      end
      if (left_channel_audio_out !== e.smp) begin
        failures++;
        $display("FAIL left #%0d got=%0d exp=%0d", tag,
                 $signed(left_channel_audio_out), $signed(e.smp));
      end
      if (right_channel_audio_out !== e.smp) begin
        failures++;
        $display("FAIL right #%0d got=%0d exp=%0d", tag,
                 $signed(right_channel_audio_out), $signed(e.smp));
      end
    end
  end

  initial begin
    logic al;
    reset = 1'b1;
    hit_miss = 2'b00;
    audio_out_allowed = 1'b1;
    @(posedge clk);
    #1;
    cyc(2'b00, 1'b1, 1'b1, -1, HH);
    // idle silence
    for (int j = 0; j < 20; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    // held hit: one tone only
    for (int j = 0; j < 100; j++)
      cyc(2'b01, 1'b1, 1'b0, (j == 0) ? -1 : j - 1, HH);
    for (int j = 0; j < 3; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    // miss tone
    for (int j = 0; j < 60; j++)
      cyc(2'b10, 1'b1, 1'b0, (j == 0) ? -1 : j - 1, MH);
    for (int j = 0; j < 3; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    // hit then miss retrigger
    for (int j = 0; j < 11; j++)
      cyc(2'b01, 1'b1, 1'b0, (j == 0) ? -1 : j - 1, HH);
    cyc(2'b10, 1'b1, 1'b0, 10, HH);
    for (int j = 0; j < 50; j++) cyc(2'b10, 1'b1, 1'b0, j, MH);
    for (int j = 0; j < 3; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    // back-pressure during a hit tone
    for (int j = 0; j < 60; j++) begin
      al = 1'($urandom_range(0, 1));
      cyc(2'b01, al, 1'b0, (j == 0) ? -1 : j - 1, HH);
    end
    for (int j = 0; j < 3; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    // reset mid miss tone with code held
    for (int j = 0; j < 15; j++)
      cyc(2'b10, 1'b1, 1'b0, (j == 0) ? -1 : j - 1, MH);
    cyc(2'b10, 1'b1, 1'b1, 14, MH);
    cyc(2'b10, 1'b1, 1'b0, -1, MH);
    for (int j = 0; j < 55; j++) cyc(2'b10, 1'b1, 1'b0, j, MH);
    // 11 never fires
    for (int j = 0; j < 10; j++) cyc(2'b11, 1'b1, 1'b0, -1, HH);
    for (int j = 0; j < 3; j++) cyc(2'b00, 1'b1, 1'b0, -1, HH);
    for (int j = 0; j < 10; j++) cyc(2'b11, 1'b1, 1'b0, -1, HH);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_miss_tone_gen.md
Name: hit_miss_tone_gen

Overview:
- Downstream of the game sound selector; consumes its 2-bit hit/miss code.
- Turns each new hit or miss event into a fixed-length square-wave tone: high pitch for a hit, low pitch for a miss.
- Drives the left/right sample interface of the DE1-SoC audio codec controller.
- Writes silence (zero samples) when no tone is playing, so the codec FIFO never starves.

Parameters:
- HIT_HALF_PERIOD, 28409, clock cycles per half-period of the hit tone (about 880 Hz at 50 MHz).
- MISS_HALF_PERIOD, 113636, clock cycles per half-period of the miss tone (about 220 Hz at 50 MHz).
- TONE_CYCLES, 10000000, tone duration in clock cycles (200 ms at 50 MHz).
- AMPLITUDE, 10000000, magnitude of the square-wave sample; positive, less than 2^31.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- hit_miss  input  2  01 = hit, 10 = miss, 00/11 = no event.
- audio_out_allowed  input  1  codec output FIFO has space.
- write_audio_out  output  1  sample write strobe to the codec.
- left_channel_audio_out  output  32  signed sample, left channel.
- right_channel_audio_out  output  32  signed sample, right channel; always equal to left.
- busy  output  1  high while a tone is playing.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, phase = 0, all counters = 0.
  - hit_miss_q = 00, busy = 0, both sample outputs = 0.
  - write_audio_out = 0 in any cycle where reset is high.
- Event detection:
  - hit_miss is registered into hit_miss_q every cycle.
  - An event fires in a cycle where hit_miss is 01 or 10 and hit_miss differs from hit_miss_q.
  - Holding a code steady produces exactly one event.
  - 00 and 11 never fire.
  - 01 changing directly to 10 fires a miss event.
- State machine: IDLE and PLAY.
  - IDLE -> PLAY on an event:
    - tone_sel is latched (0 = hit, 1 = miss).
    - dur_cnt is loaded with TONE_CYCLES-1.
    - half_cnt is loaded with the selected half-period minus 1.
    - phase is set to 1.
    - busy goes to 1 on the next edge.
  - In PLAY, each cycle:
    - dur_cnt decrements.
    - half_cnt decrements.
    - When half_cnt = 0, it reloads with the selected half-period minus 1 and phase toggles.
  - PLAY -> IDLE when dur_cnt = 0 and no event fires in that cycle. busy, phase and the samples clear on that edge.
  - An event while in PLAY (retrigger) restarts the tone: new tone_sel, full reload, phase = 1. Retrigger takes priority over expiry in the same cycle.
  - The tone lasts exactly TONE_CYCLES cycles of busy = 1 from the edge after the event.
- Samples (registered, updated every cycle):
  - PLAY, phase = 1: +AMPLITUDE.
  - PLAY, phase = 0: -AMPLITUDE (two's complement, 32-bit).
  - IDLE: 0.
  - Left and right are always identical.
- Write handshake:
  - write_audio_out = audio_out_allowed and not reset (combinational).
  - The codec captures the current sample register value when write_audio_out is high.
  - No write ever occurs while audio_out_allowed = 0.
  - Tone timing is clock-based and independent of audio_out_allowed; back-pressure drops samples and never stalls counters.
- Counter widths:
  - dur_cnt is sized by $clog2(TONE_CYCLES).
  - half_cnt is sized by $clog2 of the larger half-period.
  - No wrap-around is reachable in valid operation.
- Reset mid-tone: the next edge returns to IDLE with silence; the hit_miss_q history is cleared, so a code held through reset fires again after reset deasserts.

Test Plan:
- Bench parameters: HIT_HALF_PERIOD=4, MISS_HALF_PERIOD=10, TONE_CYCLES=40, AMPLITUDE=1000.
- Reset, then idle for 20 cycles with audio_out_allowed=1 -> write_audio_out high every cycle, samples = 0, busy = 0.
- hit_miss goes 00 -> 01 and is held for 100 cycles -> busy high for exactly 40 cycles. Samples alternate +1000 for 4 cycles and -1000 for 4 cycles, starting at +1000. Exactly one event fires, then samples return to 0.
- 00 -> 10 -> busy for 40 cycles with a 10-cycle-high / 10-cycle-low square wave. Left equals right on every cycle.
- Hit event, then 10 cycles later a miss code -> the tone restarts as a miss, and busy stays high for 40 more cycles from the retrigger.
- audio_out_allowed toggled randomly during a hit tone -> write_audio_out equals audio_out_allowed every cycle, and tone duration is still 40 cycles.
- Reset asserted for 1 cycle in the middle of a miss tone with hit_miss held at 10 -> silence and busy = 0 on the next edge, then a new miss tone starts after reset deasserts. hit_miss = 11 never starts a tone.
